// File: rtl/addsub_chunk_unit_if.sv
// Start/done handshake and result bus for the chunked add/sub unit.
// master: requester (start, op, operands); slave: the unit (status, results, flags).
interface addsub_chunk_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] z_low;
  logic [WIDTH-1:0] z_high;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  modport master (
    output start, op, a_in, b_in,
    input  busy, done, z_low, z_high,
    input  carry_out, overflow, zero
  );

  modport slave (
    input  start, op, a_in, b_in,
    output busy, done, z_low, z_high,
    output carry_out, overflow, zero
  );
endinterface

// File: rtl/addsub_chunk_unit.sv
// Multi-cycle signed add/sub, CHUNK bits per clock from the LSB up.
// Ports: clock, clear (async active-low), bus (slave). Macro ADDSUB_SAT_EN saturates z_low.
module addsub_chunk_unit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic               clock,
  input  logic               clear,
  addsub_chunk_unit_if.slave bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int OW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] z_low;
  logic [WIDTH-1:0] z_high;
  logic             carry_r;
  logic             ovf_r;
  logic             zero_r;
  logic             done_r;

  logic [OW-1:0]    ofs;
  logic [CHUNK-1:0] a_c;
  logic [CHUNK-1:0] b_c;
  logic [CHUNK-1:0] s;
  logic             c_out;
  logic             c_msb;
  logic             ovf_n;
  logic             sign_n;
  logic [WIDTH-1:0] z_cat;
  logic [WIDTH-1:0] z_fin;
  logic             accept;
  logic             last;

  assign accept = bus.start && (state != RUN);
  assign last   = (cnt == LAST);

  always_comb begin
    ofs = OW'(int'(cnt) * CHUNK);
    a_c = a_r[ofs +: CHUNK];
    b_c = b_r[ofs +: CHUNK];
    {c_out, s} = {1'b0, a_c} + {1'b0, b_c}
               + {{CHUNK{1'b0}}, carry};
    // carry into the chunk MSB recovered from its sum bit
    c_msb  = s[CHUNK-1] ^ a_c[CHUNK-1] ^ b_c[CHUNK-1];
    ovf_n  = c_msb ^ c_out;
    z_cat  = z_low;
    z_cat[ofs +: CHUNK] = s;
    // sign of the exact (WIDTH+1)-bit result
    sign_n = z_cat[WIDTH-1] ^ ovf_n;
    z_fin  = z_cat;
`ifdef ADDSUB_SAT_EN
    if (ovf_n) begin
      z_fin = sign_n ? {1'b1, {(WIDTH-1){1'b0}}}
                     : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state   <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      z_low   <= '0;
      z_high  <= '0;
      carry_r <= 1'b0;
      ovf_r   <= 1'b0;
      zero_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      unique case (1'b1)
        accept: begin
          a_r   <= bus.a_in;
          b_r   <= bus.op ? ~bus.b_in : bus.b_in;
          carry <= bus.op;
          cnt   <= '0;
          state <= RUN;
        end
        (state == RUN): begin
          carry <= c_out;
          cnt   <= cnt + CW'(1);
          if (last) begin
            z_low   <= z_fin;
            z_high  <= {WIDTH{sign_n}};
            carry_r <= c_out;
            ovf_r   <= ovf_n;
            zero_r  <= (z_fin == '0);
            done_r  <= 1'b1;
            state   <= DONE;
          end else begin
            z_low <= z_cat;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = (state == RUN);
  assign bus.done      = done_r;
  assign bus.z_low     = z_low;
  assign bus.z_high    = z_high;
  assign bus.carry_out = carry_r;
  assign bus.overflow  = ovf_r;
  assign bus.zero      = zero_r;

endmodule

// File: tb/tb_addsub_chunk_unit.sv
// Scoreboard bench for addsub_chunk_unit: 32/8 and 16/16 instances.
// Driver pushes expected results; a negedge monitor pops on done.
module tb_addsub_chunk_unit;

  logic clock;
  logic clear;
  int   cyc;
  int   checks;
  int   errors;
  int   rst_req;
  int   rst_ack;
  int   tmo_req;
  int   tmo_ack;

`ifdef ADDSUB_SAT_EN
  localparam logic [31:0] ZL_OVP = 32'h7FFF_FFFF;
  localparam logic [31:0] ZL_OVN = 32'h8000_0000;
  localparam logic        Z_OVN  = 1'b0;
  localparam logic [31:0] ZL_16  = 32'h0000_8000;
`else
  localparam logic [31:0] ZL_OVP = 32'h8000_0000;
  localparam logic [31:0] ZL_OVN = 32'h0000_0000;
  localparam logic        Z_OVN  = 1'b1;
  localparam logic [31:0] ZL_16  = 32'h0000_7FFF;
`endif

  typedef struct {
    string       n;
    logic [31:0] zl;
    logic [31:0] zh;
    logic        c;
    logic        v;
    logic        z;
    int          cyc;
  } exp_t;

  exp_t q32[$];
  exp_t q16[$];

  addsub_chunk_unit_if #(.WIDTH(32)) b32 ();
  addsub_chunk_unit_if #(.WIDTH(16)) b16 ();

  addsub_chunk_unit #(.WIDTH(32), .CHUNK(8)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (b32.slave)
  );

  addsub_chunk_unit #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clock (clock),
    .clear (clear),
    .bus   (b16.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic void chk(string n, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endfunction

  always @(negedge clock) begin
    exp_t e;
    if (rst_req != rst_ack) begin
      rst_ack = rst_req;
      chk("rst.busy", {31'b0, b32.busy}, 32'd0);
      chk("rst.done", {31'b0, b32.done}, 32'd0);
      chk("rst.z_low", b32.z_low, 32'd0);
      chk("rst.z_high", b32.z_high, 32'd0);
      chk("rst.carry", {31'b0, b32.carry_out}, 32'd0);
      chk("rst.ovf", {31'b0, b32.overflow}, 32'd0);
      chk("rst.zero", {31'b0, b32.zero}, 32'd0);
      chk("rst16.z_low", {16'b0, b16.z_low}, 32'd0);
      chk("rst16.done", {31'b0, b16.done}, 32'd0);
    end
    if (tmo_req != tmo_ack) begin
      tmo_ack = tmo_req;
      checks++;
      errors++;
      $display("FAIL timeout: done missing, got none expected done");
    end
    if (b32.done) begin
      if (q32.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done32: got done expected none");
      end else begin
        e = q32.pop_front();
        chk({e.n, ".z_low"}, b32.z_low, e.zl);
        chk({e.n, ".z_high"}, b32.z_high, e.zh);
        chk({e.n, ".carry"}, {31'b0, b32.carry_out}, {31'b0, e.c});
        chk({e.n, ".ovf"}, {31'b0, b32.overflow}, {31'b0, e.v});
        chk({e.n, ".zero"}, {31'b0, b32.zero}, {31'b0, e.z});
        chk({e.n, ".busy"}, {31'b0, b32.busy}, 32'd0);
        chk({e.n, ".cycle"}, cyc, e.cyc);
      end
    end
    if (b16.done) begin
      if (q16.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done16: got done expected none");
      end else begin
        e = q16.pop_front();
        chk({e.n, ".z_low"}, {16'b0, b16.z_low}, e.zl);
        chk({e.n, ".z_high"}, {16'b0, b16.z_high}, e.zh);
        chk({e.n, ".carry"}, {31'b0, b16.carry_out}, {31'b0, e.c});
        chk({e.n, ".ovf"}, {31'b0, b16.overflow}, {31'b0, e.v});
        chk({e.n, ".zero"}, {31'b0, b16.zero}, {31'b0, e.z});
        chk({e.n, ".cycle"}, cyc, e.cyc);
      end
    end
  end

  task automatic wait_empty();
    for (int i = 0; i < 40; i++) begin
      if (q32.size() == 0 && q16.size() == 0) break;
      @(posedge clock);
    end
    if (q32.size() != 0 || q16.size() != 0) begin
      tmo_req = tmo_req + 1;
      q32.delete();
      q16.delete();
    end
    #1;
  endtask

  task automatic issue32(string n, logic [31:0] a, logic [31:0] b,
                         logic o, logic [31:0] zl, logic [31:0] zh,
                         logic c, logic v, logic z);
    q32.push_back('{n, zl, zh, c, v, z, cyc + 5});
    b32.a_in  = a;
    b32.b_in  = b;
    b32.op    = o;
    b32.start = 1'b1;
    @(posedge clock);
    #1;
    b32.start = 1'b0;
    b32.a_in  = 32'hDEAD_BEEF;
    b32.b_in  = 32'h1234_5678;
    b32.op    = ~o;
    wait_empty();
  endtask

  task automatic issue16(string n, logic [15:0] a, logic [15:0] b,
                         logic o, logic [31:0] zl, logic [31:0] zh,
                         logic c, logic v, logic z);
    q16.push_back('{n, zl, zh, c, v, z, cyc + 2});
    b16.a_in  = a;
    b16.b_in  = b;
    b16.op    = o;
    b16.start = 1'b1;
    @(posedge clock);
    #1;
    b16.start = 1'b0;
    b16.a_in  = 16'h5555;
    wait_empty();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    checks = 0;
    errors = 0;
    rst_req = 0;
    rst_ack = 0;
    tmo_req = 0;
    tmo_ack = 0;
    clear = 1'b1;
    b32.start = 1'b0;
    b32.op = 1'b0;
    b32.a_in = '0;
    b32.b_in = '0;
    b16.start = 1'b0;
    b16.op = 1'b0;
    b16.a_in = '0;
    b16.b_in = '0;
    #2;
    clear = 1'b0;
    rst_req = rst_req + 1;
    @(posedge clock);
    @(posedge clock);
    #1;
    clear = 1'b1;

    issue32("add_neg", 32'hFFFF_FFF4, 32'hFFFF_FFFB, 1'b0,
            32'hFFFF_FFEF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    issue32("sub_neg", 32'hFFFF_FFF4, 32'hFFFF_FFFB, 1'b1,
            32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    issue32("sub_eq", 32'd5, 32'd5, 1'b1,
            32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
    issue32("ovf_pos", 32'h7FFF_FFFF, 32'd1, 1'b0,
            ZL_OVP, 32'd0, 1'b0, 1'b1, 1'b0);
    issue32("ovf_neg", 32'h8000_0000, 32'h8000_0000, 1'b0,
            ZL_OVN, 32'hFFFF_FFFF, 1'b1, 1'b1, Z_OVN);
    issue32("sub_borrow", 32'd1, 32'd2, 1'b1,
            32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    issue32("add_mixed", 32'h1234_5678, 32'h8765_4321, 1'b0,
            32'h9999_9999, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    issue32("add_zero", 32'd0, 32'd0, 1'b0,
            32'd0, 32'd0, 1'b0, 1'b0, 1'b1);

    // start held through RUN, then accepted in the DONE cycle
    c = cyc;
    q32.push_back('{"hold_a", 32'd3, 32'd0, 1'b0, 1'b0, 1'b0, c + 5});
    b32.a_in  = 32'd1;
    b32.b_in  = 32'd2;
    b32.op    = 1'b0;
    b32.start = 1'b1;
    @(posedge clock);
    #1;
    b32.a_in = 32'd100;
    b32.b_in = 32'd200;
    q32.push_back('{"hold_b", 32'd300, 32'd0, 1'b0, 1'b0, 1'b0,
                    c + 10});
    repeat (5) @(posedge clock);
    #1;
    b32.start = 1'b0;
    b32.a_in  = 32'hDEAD_BEEF;
    wait_empty();

    // reset two cycles after start aborts the op
    b32.a_in  = 32'hFFFF_FFFF;
    b32.b_in  = 32'd1;
    b32.op    = 1'b0;
    b32.start = 1'b1;
    @(posedge clock);
    #1;
    b32.start = 1'b0;
    @(posedge clock);
    #1;
    clear = 1'b0;
    rst_req = rst_req + 1;
    @(posedge clock);
    @(posedge clock);
    #1;
    clear = 1'b1;
    repeat (8) @(posedge clock);
    #1;

    issue32("post_rst", 32'h10, 32'h20, 1'b1,
            32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);

    issue16("w16_sub", 16'h8000, 16'h0001, 1'b1,
            ZL_16, 32'h0000_FFFF, 1'b1, 1'b1, 1'b0);

    repeat (2) @(negedge clock);
    #1;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
